// File: rtl/otf_sd_converter_pkg.sv
// Shared definitions for the on-the-fly signed-digit converter.
//   SD_*       : (dp,dn) digit encodings; 2'b11 is a redundant zero
//   state_t    : converter FSM state encoding
//   sd_digit_t : one signed digit as delivered by the redundant adder stage
//   clog2      : bits needed to count 0..v-1
package otf_sd_converter_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic dp;
    logic dn;
  } sd_digit_t;

  // Number of bits required to hold values 0..v-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 0; i < 32; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/otf_sd_converter_if.sv
// Digit-in / result-out bundle of the on-the-fly converter.
//   master : digit source (drives start, din_valid, dp, dn; sees busy, done, q)
//   slave  : converter side
interface otf_sd_converter_if #(
  parameter int unsigned NDIG = 8
) ();

  logic            start;
  logic            din_valid;
  logic            dp;
  logic            dn;
  logic            busy;
  logic            done;
  logic [NDIG:0]   q;

  modport master (
    output start, din_valid, dp, dn,
    input  busy, done, q
  );

  modport slave (
    input  start, din_valid, dp, dn,
    output busy, done, q
  );

endinterface

// File: rtl/otf_sd_converter_qqm_cell.sv
// Q/QM next-value mux of the on-the-fly conversion (purely combinational).
//   q, qm      : current Q and QM (QM == Q-1)
//   digit      : signed digit being appended
//   q_next_c   : Q after appending the digit
//   qm_next_c  : QM after appending the digit
module otf_qqm_cell
  import otf_sd_converter_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  sd_digit_t    digit,
  output logic [W-1:0] q_next_c,
  output logic [W-1:0] qm_next_c
);

  logic [W-1:0] q2;
  logic [W-1:0] qm2;

  assign q2  = q << 1;
  assign qm2 = qm << 1;

  // Append the digit; a negative digit borrows, so Q is rebuilt from QM.
  always_comb begin
    q_next_c  = q2;
    qm_next_c = qm2 | W'(1);
    case ({digit.dp, digit.dn})
      SD_POS: begin
        q_next_c  = q2 | W'(1);
        qm_next_c = q2;
      end
      SD_NEG: begin
        q_next_c  = qm2 | W'(1);
        qm_next_c = qm2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/otf_sd_converter.sv
// Digit-serial on-the-fly converter: radix-2 signed digits (MSB first) to an
// NDIG+1 bit two's-complement result without a final carry-propagate add.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of otf_sd_converter_if
//              start/din_valid/dp/dn in; busy, done (1-cycle pulse), q out
module otf_sd_converter
  import otf_sd_converter_pkg::*;
#(
  parameter int unsigned NDIG = 8
) (
  input logic               clk,
  input logic               rst,
  otf_sd_converter_if.slave bus
);

  localparam int unsigned W  = NDIG + 1;
  localparam int unsigned CW = clog2(NDIG);

  state_t         state_r;
  state_t         state_next;
  logic [W-1:0]   q_r;
  logic [W-1:0]   qm_r;
  logic [W-1:0]   q_next_c;
  logic [W-1:0]   qm_next_c;
  logic [CW-1:0]  cnt_r;
  sd_digit_t      digit_c;
  logic           consume_c;
  logic           last_c;
  logic           busy_next_c;
  logic           done_next_c;

  assign digit_c   = {bus.dp, bus.dn};
  // start always wins over a digit arriving in the same cycle
  assign consume_c = (state_r == ST_ACC) && bus.din_valid && !bus.start;
  assign last_c    = consume_c && (cnt_r == CW'(NDIG - 1));

  otf_qqm_cell #(.W(W)) u_cell (
    .q         (q_r),
    .qm        (qm_r),
    .digit     (digit_c),
    .q_next_c  (q_next_c),
    .qm_next_c (qm_next_c)
  );

  // State register; busy/done are registered copies of the state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state_r  <= state_next;
      bus.busy <= busy_next_c;
      bus.done <= done_next_c;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    if (bus.start) begin
      state_next = ST_ACC;
    end else begin
      case (state_r)
        ST_IDLE: state_next = ST_IDLE;
        ST_ACC:  if (last_c) state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode of the upcoming state.
  always_comb begin
    busy_next_c = 1'b0;
    done_next_c = 1'b0;
    case (state_next)
      ST_ACC:  busy_next_c = 1'b1;
      ST_DONE: done_next_c = 1'b1;
      default: ;
    endcase
  end

  // Q/QM accumulators, digit counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= '0;
      qm_r  <= '1;
      cnt_r <= '0;
      bus.q <= '0;
    end else if (bus.start) begin
      q_r   <= '0;
      qm_r  <= '1;
      cnt_r <= '0;
    end else if (consume_c) begin
      q_r   <= q_next_c;
      qm_r  <= qm_next_c;
      cnt_r <= cnt_r + CW'(1);
      if (last_c) bus.q <= q_next_c;
    end
  end

endmodule

// File: tb/tb_otf_sd_converter.sv
// Scoreboard bench for otf_sd_converter (NDIG=4, 5-bit results).
module tb_otf_sd_converter;
  import otf_sd_converter_pkg::*;

  localparam int unsigned NDIG = 4;
  localparam int unsigned W    = NDIG + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  otf_sd_converter_if #(.NDIG(NDIG)) bus ();

  otf_sd_converter #(.NDIG(NDIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic s, input logic dv, input logic p, input logic n);
    bus.start     = s;
    bus.din_valid = dv;
    bus.dp        = p;
    bus.dn        = n;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.din_valid = 1'b0;
    bus.dp        = 1'b0;
    bus.dn        = 1'b0;
  endtask

  // d: 1=+1, -1=-1, 0=zero (00), anything else = redundant zero (11)
  task automatic digit(input int d);
    case (d)
      1:       cyc(1'b0, 1'b1, 1'b1, 1'b0);
      -1:      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      0:       cyc(1'b0, 1'b1, 1'b0, 1'b0);
      default: cyc(1'b0, 1'b1, 1'b1, 1'b1);
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_op();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation;
  // while accumulating, QM must track Q-1.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual q=%b expected no done at %0t", bus.q, $time);
      end else begin
        check("result_q", bus.q, exp_q.pop_front());
      end
    end
    if (bus.busy === 1'b1) check("qm_invariant", dut.qm_r, dut.q_r - W'(1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    logic [1:0] code;
    int d;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.din_valid = 1'b0;
    bus.dp        = 1'b0;
    bus.dn        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", W'(bus.busy), W'(0));
    check("reset_done", W'(bus.done), W'(0));
    check("reset_q", bus.q, W'(0));
    rst = 1'b0;
    idle(1);

    // +1,0,-1,+1 -> 7, done one cycle after the last digit
    exp_q.push_back(5'b00111);
    start_op();
    check("busy_after_start", W'(bus.busy), W'(1));
    digit(1); digit(0); digit(-1);
    check("done_not_early", W'(bus.done), W'(0));
    digit(1);
    check("done_latency", W'(bus.done), W'(1));
    idle(1);
    check("done_one_cycle", W'(bus.done), W'(0));
    check("busy_idle", W'(bus.busy), W'(0));

    // all -1 -> -15, all +1 -> 15
    exp_q.push_back(5'b10001);
    start_op();
    repeat (4) digit(-1);
    idle(1);
    exp_q.push_back(5'b01111);
    start_op();
    repeat (4) digit(1);
    idle(1);

    // reset mid-operation clears everything; later digits ignored
    start_op();
    digit(1); digit(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", W'(bus.busy), W'(0));
    check("midrst_done", W'(bus.done), W'(0));
    check("midrst_q", bus.q, W'(0));
    digit(1); digit(1); digit(1); digit(1);
    check("after_rst_busy", W'(bus.busy), W'(0));
    idle(2);

    // stall between digits 2 and 3 -> 1
    exp_q.push_back(5'b00001);
    start_op();
    digit(1); digit(-1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("stall_busy", W'(bus.busy), W'(1));
    end
    digit(-1); digit(-1);
    idle(1);

    // start together with a digit restarts; only one done
    exp_q.push_back(5'b00000);
    start_op();
    digit(1); digit(1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    digit(0); digit(0); digit(0); digit(3);
    idle(2);

    // start during DONE: done still pulses, next conversion begins cleared
    exp_q.push_back(5'b00011);
    exp_q.push_back(5'b11001);
    start_op();
    digit(0); digit(1); digit(0); digit(-1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("restart_busy", W'(bus.busy), W'(1));
    check("restart_done", W'(bus.done), W'(0));
    digit(-1); digit(0); digit(0); digit(1);
    idle(1);

    // din_valid in DONE and IDLE is ignored; q is held
    exp_q.push_back(5'b01111);
    start_op();
    repeat (4) digit(1);
    digit(-1);
    check("dv_in_done_busy", W'(bus.busy), W'(0));
    digit(1);
    check("dv_in_idle_busy", W'(bus.busy), W'(0));
    check("q_held", bus.q, 5'b01111);
    idle(1);

    // random digits and stalls against a signed-sum model
    for (int op = 0; op < 200; op++) begin
      sum = 0;
      start_op();
      for (int k = 0; k < int'(NDIG); k++) begin
        idle(int'($urandom_range(0, 2)));
        code = 2'($urandom_range(0, 3));
        d = (code == SD_POS) ? 1 : (code == SD_NEG) ? -1 : 0;
        sum = sum * 2 + d;
        if (k == int'(NDIG) - 1) exp_q.push_back(W'(sum));
        cyc(1'b0, 1'b1, code[1], code[0]);
      end
      idle(1);
    end

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual pending=%0d expected pending=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
